systolic_skew_feeder: RTL and testbench
=======================================

Name: systolic_skew_feeder

Overview:
- Upstream operand feeder for the FP32 MAC systolic array.
- Accepts one column of N IEEE-754 single-precision operands per beat through a valid/ready handshake.
- Staggers lane i by i extra cycles so operands meet their partner operands at the correct PE wavefront.
- After the last beat, injects +0.0 flush beats so the skewed tail drains; a*0.0 + c = c keeps the accumulators unchanged.

Parameters:
- N, 4, number of array rows/lanes (>=1).
- DW, 32, operand width; the FP32 word format, fixed at 32.
- CW, 16, width of the beat counter.

Ports:
- clk  input  1  single clock; all state on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- in_valid  input  1  upstream beat valid.
- in_ready  output  1  feeder can accept a beat.
- in_data  input  N*DW  lane i at bits [i*DW +: DW].
- in_last  input  1  marks the final beat of a tile; sampled only on an accepted beat.
- out_data  output  N*DW  skewed operands into array row i.
- out_vld  output  N  per-row valid: 1 = real operand, 0 = flush zero or idle.
- out_en  output  1  array advance strobe; PEs update only when high.
- done  output  1  one-cycle pulse when a tile is fully drained.
- tile_len  output  CW  accepted beat count of the last completed tile; valid while done=1 and held until the next done.

Behaviour:
- Reset values (rst_n=0 at clock edge): out_data=0, out_vld=0, out_en=0, done=0, tile_len=0, in_ready=0. All delay lines are cleared, the beat counter is 0, and the FSM is in IDLE. Reset mid-FLUSH aborts the tile with no done pulse.
- FSM states:
  - IDLE: in_ready=1. An accepted beat goes to STREAM. If that beat has in_last, go to FLUSH when N>1, or to DONE when N=1.
  - STREAM: in_ready=1. An accepted beat with in_last goes to FLUSH (N>1) or to DONE (N=1).
  - FLUSH: in_ready=0. Pushes N-1 zero beats, one per cycle, counted by a flush counter; then goes to DONE.
  - DONE: in_ready=0. done=1 for exactly one cycle; tile_len is updated; returns to IDLE.
- Advance condition: adv = (in_valid & in_ready) | (state==FLUSH).
  - Delay lines shift only on adv.
  - In-stream bubbles (in_valid=0) freeze every lane, which preserves wavefront alignment.
- Lane i path is a shift register of depth i+1 carrying {data, vld}.
  - Pushed value is {in_data lane i, 1} on an accepted beat and {32'h0000_0000, 0} in FLUSH.
  - Latency from acceptance to lane-i output is i+1 advances.
- out_en is registered: out_en(t+1) = adv(t). It is coincident with out_data updates.
- Beat counter:
  - Increments on each accepted beat and saturates at 2^CW-1.
  - Copied to tile_len on entry to DONE, then cleared.
- Boundary conditions:
  - in_valid with in_ready=0 (FLUSH or DONE): the beat is not accepted, and upstream must hold in_data/in_valid.
  - in_last=1 on a non-accepted cycle is ignored.
  - Single-beat tile: lane i shows the beat after i+1 cycles, then zeros.
  - New tile accepted in the cycle right after the done pulse: no overlap with the previous tile, since the lines are already drained of valid data.
  - N=1: no FLUSH state visited.

Decomposition:
- Shared package systolic_pkg holds:
  - FP32_W=32 and FP32_ZERO=32'h0000_0000.
  - FP32_ONE=32'h3F80_0000 for benches.
  - State enum {IDLE, STREAM, FLUSH, DONE}.
- One sub-module, skew_delay_line: parameter DEPTH, DW; ports clk, rst_n, en, din, dout. It is instantiated N times via generate with DEPTH=i+1.

Test Plan:
- Reset, then 3 beats back-to-back with N=4, lanes all 1.0/2.0/3.0 (0x3F800000/0x40000000/0x40400000), last on beat 3 → row0 shows 1.0,2.0,3.0 at cycles 1-3; row3 shows 1.0 at cycle 4 and 3.0 at cycle 6; out_vld[3]=0 after; done pulses once; tile_len=3.
- Bubble: beat1, in_valid=0 for 2 cycles, beat2(last) → out_en low for exactly 2 cycles; row-to-row skew unchanged (row i lags row0 by i advances); tile_len=2.
- Single-beat tile, in_last=1, lane i = i+1.0 → in_ready=0 for N cycles (3 FLUSH + 1 DONE); row3 emits 4.0 (0x40800000) then zeros with out_vld=0; done pulses.
- in_valid held high with a new tile during FLUSH → no acceptance until IDLE; first beat of tile 2 accepted the cycle after done; tile 1 outputs uncorrupted.
- rst_n=0 during second FLUSH cycle → next cycle all outputs 0, no done pulse, in_ready=0; after release in_ready=1 and a fresh 1-beat tile gives tile_len=1.
- 70000-beat tile with CW=16 → tile_len saturates at 0xFFFF.

Source files
------------

// File: rtl/systolic_skew_feeder_pkg.sv
// Shared constants and state encoding for the systolic operand feeder.
package systolic_pkg;

    localparam int          FP32_W    = 32;
    localparam logic [31:0] FP32_ZERO = 32'h0000_0000;
    localparam logic [31:0] FP32_ONE  = 32'h3F80_0000;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        FLUSH  = 2'd2,
        DONE   = 2'd3
    } feeder_state_e;

endpackage

// File: rtl/systolic_skew_feeder_delay_line.sv
// Enable-gated shift register; one instance per array row sets that row's skew.
module skew_delay_line #(
    parameter int DEPTH = 1,
    parameter int DW    = 33
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout
);

    logic [DW-1:0] stage_q [DEPTH];

    // Shift one stage per advance; bubbles freeze the whole line.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < DEPTH; k++) begin
                stage_q[k] <= '0;
            end
        end else if (en) begin
            stage_q[0] <= din;
            for (int k = 1; k < DEPTH; k++) begin
                stage_q[k] <= stage_q[k-1];
            end
        end
    end

    assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/systolic_skew_feeder.sv
// Operand feeder: accepts N-lane FP32 columns, skews lane i by i advances,
// then pushes N-1 zero beats so the skewed tail drains out of the array.
//
// state  | meaning
// IDLE   | waiting for the first beat of a tile, in_ready=1
// STREAM | accepting beats until in_last, in_ready=1
// FLUSH  | pushing N-1 zero beats, in_ready=0
// DONE   | one-cycle done pulse with tile_len valid, in_ready=0
module systolic_skew_feeder
    import systolic_pkg::*;
#(
    parameter int N  = 4,
    parameter int DW = 32,
    parameter int CW = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [N*DW-1:0] in_data,
    input  logic            in_last,
    output logic [N*DW-1:0] out_data,
    output logic [N-1:0]    out_vld,
    output logic            out_en,
    output logic            done,
    output logic [CW-1:0]   tile_len
);

    localparam bit HAS_FLUSH  = (N > 1);
    localparam int FCW        = (N > 2) ? $clog2(N - 1) : 1;
    localparam int FLUSH_INIT = (N > 1) ? N - 2 : 0;

    feeder_state_e  state_q, state_d;
    logic [FCW-1:0] flush_cnt_q, flush_cnt_d;
    logic [CW-1:0]  beat_cnt_q, beat_cnt_d;
    logic [CW-1:0]  tile_len_q, tile_len_d;
    logic [CW-1:0]  beat_cnt_inc;
    logic           run_q;
    logic           out_en_q;
    logic           accept;
    logic           adv;

    // run_q keeps in_ready low while reset is held and for the release cycle.
    assign in_ready = run_q & ((state_q == IDLE) | (state_q == STREAM));
    assign accept   = in_valid & in_ready;
    assign adv      = accept | (state_q == FLUSH);
    assign done     = (state_q == DONE);
    assign tile_len = tile_len_q;
    assign out_en   = out_en_q;

    assign beat_cnt_inc = (beat_cnt_q == {CW{1'b1}}) ? beat_cnt_q : beat_cnt_q + CW'(1);

    // State, counters and the advance strobe register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            flush_cnt_q <= '0;
            beat_cnt_q  <= '0;
            tile_len_q  <= '0;
            run_q       <= 1'b0;
            out_en_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            beat_cnt_q  <= beat_cnt_d;
            tile_len_q  <= tile_len_d;
            run_q       <= 1'b1;
            out_en_q    <= adv;
        end
    end

    // Next-state decode; tile_len is captured on the transition into DONE.
    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        beat_cnt_d  = beat_cnt_q;
        tile_len_d  = tile_len_q;
        case (state_q)
            IDLE, STREAM: begin
                if (accept) begin
                    beat_cnt_d = beat_cnt_inc;
                    state_d    = STREAM;
                    if (in_last) begin
                        if (HAS_FLUSH) begin
                            state_d     = FLUSH;
                            flush_cnt_d = FCW'(FLUSH_INIT);
                        end else begin
                            state_d    = DONE;
                            tile_len_d = beat_cnt_inc;
                            beat_cnt_d = '0;
                        end
                    end
                end
            end
            FLUSH: begin
                if (flush_cnt_q == '0) begin
                    state_d    = DONE;
                    tile_len_d = beat_cnt_q;
                    beat_cnt_d = '0;
                end else begin
                    flush_cnt_d = flush_cnt_q - FCW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    for (genvar i = 0; i < N; i++) begin : g_lane
        logic [DW:0] lane_din;
        logic [DW:0] lane_dout;

        // Real operands carry vld=1; flush beats are +0.0 with vld=0.
        assign lane_din = accept ? {in_data[i*DW +: DW], 1'b1} : {FP32_ZERO, 1'b0};

        skew_delay_line #(
            .DEPTH (i + 1),
            .DW    (DW + 1)
        ) u_line (
            .clk   (clk),
            .rst_n (rst_n),
            .en    (adv),
            .din   (lane_din),
            .dout  (lane_dout)
        );

        assign out_data[i*DW +: DW] = lane_dout[DW:1];
        assign out_vld[i]           = lane_dout[0];
    end

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Scoreboard bench for the skew feeder: every accepted beat (and the flush
// zeros that follow a last beat) is queued per lane, and each out_en cycle
// pops one entry per lane and compares it with the row output.
module tb_systolic_skew_feeder;
    import systolic_pkg::*;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int CW = 16;

    logic            clk;
    logic            rst_n;
    logic            in_valid;
    logic            in_ready;
    logic [N*DW-1:0] in_data;
    logic            in_last;
    logic [N*DW-1:0] out_data;
    logic [N-1:0]    out_vld;
    logic            out_en;
    logic            done;
    logic [CW-1:0]   tile_len;

    systolic_skew_feeder #(.N(N), .DW(DW), .CW(CW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_last  (in_last),
        .out_data (out_data),
        .out_vld  (out_vld),
        .out_en   (out_en),
        .done     (done),
        .tile_len (tile_len)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    logic [DW:0] lane_q [N][$];
    int unsigned tl_q [$];
    int unsigned beat_cnt;
    int          done_seen;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < N; i++) begin
            lane_q[i].delete();
            for (int k = 0; k < i; k++) lane_q[i].push_back('0);
        end
        tl_q.delete();
        beat_cnt = 0;
    endfunction

    task automatic monitor();
        if (out_en) begin
            for (int i = 0; i < N; i++) begin
                if (lane_q[i].size() == 0) begin
                    check_val("out_en_spurious", {63'd0, out_en}, 64'd0);
                end else begin
                    check_val($sformatf("row%0d", i), {31'd0, out_data[i*DW +: DW], out_vld[i]},
                              {31'd0, lane_q[i].pop_front()});
                end
            end
        end
        if (done) begin
            if (tl_q.size() == 0) begin
                check_val("done_spurious", {63'd0, done}, 64'd0);
            end else begin
                check_val("tile_len", {48'd0, tile_len}, {32'd0, tl_q.pop_front()});
                done_seen++;
            end
        end
    endtask

    // One clock: drive at negedge, model the handshake, check at next negedge.
    task automatic step(input logic v, input logic [N*DW-1:0] d, input logic last, output logic acc);
        logic was_rst;
        logic [N*DW-1:0] dd;
        in_valid = v;
        in_data  = d;
        in_last  = last;
        dd       = d;
        was_rst  = !rst_n;
        acc      = rst_n && v && in_ready;
        if (acc) begin
            for (int i = 0; i < N; i++) lane_q[i].push_back({dd[i*DW +: DW], 1'b1});
            if (beat_cnt < 65535) beat_cnt++;
            if (last) begin
                for (int k = 0; k < N - 1; k++)
                    for (int i = 0; i < N; i++) lane_q[i].push_back({FP32_ZERO, 1'b0});
                tl_q.push_back(beat_cnt);
                beat_cnt = 0;
            end
        end
        @(negedge clk);
        if (was_rst) begin
            model_reset();
            check_val("rst_out_data", {63'd0, |out_data}, 64'd0);
            check_val("rst_out_vld", {60'd0, out_vld}, 64'd0);
            check_val("rst_out_en", {63'd0, out_en}, 64'd0);
            check_val("rst_done", {63'd0, done}, 64'd0);
            check_val("rst_tile_len", {48'd0, tile_len}, 64'd0);
            check_val("rst_in_ready", {63'd0, in_ready}, 64'd0);
        end else begin
            monitor();
        end
    endtask

    task automatic idle(input int cycles);
        logic a;
        for (int c = 0; c < cycles; c++) step(1'b0, '0, 1'b0, a);
    endtask

    task automatic wait_ready();
        int c;
        c = 0;
        while (!in_ready && c < 10) begin
            idle(1);
            c++;
        end
        check_val("ready_timeout", {63'd0, in_ready}, 64'd1);
    endtask

    function automatic logic [N*DW-1:0] splat(input logic [DW-1:0] w);
        logic [N*DW-1:0] r;
        for (int i = 0; i < N; i++) r[i*DW +: DW] = w;
        return r;
    endfunction

    initial begin
        logic            a;
        int              d0;
        int              cnt;
        logic [N*DW-1:0] lanes;

        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        in_last  = 1'b0;
        model_reset();
        done_seen = 0;

        // Reset values
        idle(3);
        rst_n = 1'b1;
        wait_ready();

        // Three back-to-back beats, last on beat 3
        d0 = done_seen;
        step(1'b1, splat(32'h3F80_0000), 1'b0, a);
        check_val("t1_acc1", {63'd0, a}, 64'd1);
        step(1'b1, splat(32'h4000_0000), 1'b0, a);
        step(1'b1, splat(32'h4040_0000), 1'b1, a);
        idle(8);
        check_val("t1_done_count", done_seen - d0, 1);

        // Bubble of two cycles mid-tile
        d0 = done_seen;
        step(1'b1, splat(32'h40A0_0000), 1'b0, a);
        step(1'b0, '0, 1'b0, a);
        check_val("bubble_en1", {63'd0, out_en}, 64'd0);
        step(1'b0, '0, 1'b0, a);
        check_val("bubble_en2", {63'd0, out_en}, 64'd0);
        step(1'b1, splat(32'h40C0_0000), 1'b1, a);
        check_val("bubble_en_resume", {63'd0, out_en}, 64'd1);
        idle(8);
        check_val("t2_done_count", done_seen - d0, 1);

        // Single-beat tile, lane i = i+1.0; busy for N cycles
        d0 = done_seen;
        lanes = {32'h4080_0000, 32'h4040_0000, 32'h4000_0000, 32'h3F80_0000};
        step(1'b1, lanes, 1'b1, a);
        cnt = 0;
        while (!in_ready && cnt < 20) begin
            idle(1);
            cnt++;
        end
        check_val("single_busy_cycles", cnt, N);
        idle(4);
        check_val("t3_done_count", done_seen - d0, 1);

        // New tile held valid during FLUSH: accepted right after done
        d0 = done_seen;
        step(1'b1, splat(32'h4110_0000), 1'b0, a);
        step(1'b1, splat(32'h4120_0000), 1'b1, a);
        cnt = 0;
        a = 1'b0;
        while (!a && cnt < 20) begin
            step(1'b1, splat(32'h4130_0000), 1'b1, a);
            cnt++;
        end
        check_val("held_accept_cycle", cnt, N + 1);
        idle(8);
        check_val("t4_done_count", done_seen - d0, 2);

        // Reset during second FLUSH cycle aborts the tile
        d0 = done_seen;
        step(1'b1, splat(32'h4140_0000), 1'b1, a);
        idle(1);
        rst_n = 1'b0;
        idle(1);
        rst_n = 1'b1;
        idle(1);
        check_val("abort_no_done", done_seen - d0, 0);
        wait_ready();
        step(1'b1, splat(32'h4150_0000), 1'b1, a);
        check_val("post_rst_acc", {63'd0, a}, 64'd1);
        idle(8);
        check_val("t5_done_count", done_seen - d0, 1);

        // Random bubbles over a 6-beat tile
        d0 = done_seen;
        cnt = 0;
        for (int b = 0; b < 6 && cnt < 200; cnt++) begin
            logic v;
            v = 1'($urandom_range(0, 1));
            for (int i = 0; i < N; i++) lanes[i*DW +: DW] = $urandom;
            step(v, lanes, (b == 5), a);
            if (a) b++;
        end
        idle(8);
        check_val("t6_done_count", done_seen - d0, 1);

        // Beat counter saturation
        d0 = done_seen;
        for (int b = 0; b < 70000; b++) begin
            for (int i = 0; i < N; i++) lanes[i*DW +: DW] = $urandom;
            step(1'b1, lanes, (b == 69999), a);
        end
        idle(8);
        check_val("t7_done_count", done_seen - d0, 1);
        check_val("sat_tile_len", {48'd0, tile_len}, 64'hFFFF);

        for (int i = 0; i < N; i++) check_val("lane_residual", lane_q[i].size(), i);
        check_val("tile_pending", tl_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
